// File: rtl/intr_req_arbiter.sv
// -----------------------------------------------------------------------------
// intr_req_arbiter
//
// Round-robin arbiter that shares a single interrupt/acknowledge channel among
// N_REQ level-sensitive requesters and drives the interrupt handler's
// channel-control code. Each grant passes through three phases:
//   IDLE    : channel enabled, waiting for a request        (cc_mux = 01)
//   GRANT   : one requester owns the channel                 (cc_mux = 10)
//   RELEASE : one-cycle acknowledge/release of the channel   (cc_mux = 11)
// A grant that is not acknowledged within TIMEOUT cycles is reclaimed, and
// the reclaim is flagged with a one-cycle timeout pulse.
//
// Parameters
//   N_REQ    : number of requesters (2..8)
//   TIMEOUT  : maximum open-grant duration in cycles (2..255)
//
// Ports
//   clock    : in  - rising-edge clock
//   reset_n  : in  - asynchronous active-low reset
//   req      : in  - level request per requester, bit i = requester i
//   ack      : in  - handler reports service complete (used only in GRANT)
//   grant    : out - one-hot grant or zero (registered)
//   grant_id : out - index of current / most recent grantee (registered)
//   cc_mux   : out - channel control code 01/10/11, never 00 (registered)
//   busy     : out - high in GRANT and RELEASE (registered)
//   timeout  : out - one-cycle pulse in a RELEASE caused by expiry (registered)
// -----------------------------------------------------------------------------
module intr_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 8,
  localparam int ID_W   = $clog2(N_REQ),
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic [1:0]       cc_mux,
  output logic             busy,
  output logic             timeout
);

  // Channel-control codes driven towards the handler.
  localparam logic [1:0] CC_IDLE    = 2'b01;
  localparam logic [1:0] CC_SERVICE = 2'b10;
  localparam logic [1:0] CC_RELEASE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b01,
    ST_GRANT   = 2'b10,
    ST_RELEASE = 2'b11
  } state_t;

  state_t             state_r;
  logic [ID_W-1:0]    ptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [N_REQ-1:0]   grant_r;
  logic [ID_W-1:0]    grant_id_r;
  logic [1:0]         cc_mux_r;
  logic               busy_r;
  logic               timeout_r;

  logic               pick_found_s;
  logic [ID_W-1:0]    pick_idx_s;
  logic [N_REQ-1:0]   pick_onehot_s;

  // Round-robin search: first set request bit scanning start, start+1, ...
  // modulo n_req. Bit ID_W of the result flags that a request was found.
  // Scanning downwards lets the lowest rotational offset overwrite the rest.
  function automatic logic [ID_W:0] rr_pick(
    input logic [N_REQ-1:0] req_v,
    input logic [ID_W-1:0]  start
  );
    logic [ID_W:0] res;
    int            idx;
    res = {(ID_W + 1){1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (req_v[idx]) begin
        res = {1'b1, ID_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Pointer successor with an explicit wrap so non-power-of-2 sizes are safe.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    logic [ID_W-1:0] res;
    if (id >= ID_W'(N_REQ - 1)) begin
      res = {ID_W{1'b0}};
    end else begin
      res = id + ID_W'(1);
    end
    return res;
  endfunction

  // Winner selection and its one-hot form, evaluated every cycle for IDLE.
  always_comb begin
    pick_found_s  = 1'b0;
    pick_idx_s    = {ID_W{1'b0}};
    pick_onehot_s = {N_REQ{1'b0}};
    {pick_found_s, pick_idx_s} = rr_pick(req, ptr_r);
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_found_s && (pick_idx_s == ID_W'(i))) begin
        pick_onehot_s[i] = 1'b1;
      end else begin
        pick_onehot_s[i] = 1'b0;
      end
    end
  end

  // Phase sequencer with every output registered alongside the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {ID_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      grant_r    <= {N_REQ{1'b0}};
      grant_id_r <= {ID_W{1'b0}};
      cc_mux_r   <= CC_IDLE;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          timeout_r <= 1'b0;
          if (pick_found_s) begin
            state_r    <= ST_GRANT;
            grant_id_r <= pick_idx_s;
            grant_r    <= pick_onehot_s;
            cnt_r      <= {CNT_W{1'b0}};
            cc_mux_r   <= CC_SERVICE;
            busy_r     <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            grant_r  <= {N_REQ{1'b0}};
            cc_mux_r <= CC_IDLE;
            busy_r   <= 1'b0;
          end
        end

        ST_GRANT: begin
          // cnt counts completed grant cycles; it saturates as a safety net.
          if (cnt_r != CNT_W'(TIMEOUT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
          busy_r <= 1'b1;
          // ack outranks withdrawal, which outranks expiry.
          if (ack || !req[grant_id_r]) begin
            state_r   <= ST_RELEASE;
            grant_r   <= {N_REQ{1'b0}};
            cc_mux_r  <= CC_RELEASE;
            timeout_r <= 1'b0;
          end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
            state_r   <= ST_RELEASE;
            grant_r   <= {N_REQ{1'b0}};
            cc_mux_r  <= CC_RELEASE;
            timeout_r <= 1'b1;
          end else begin
            state_r   <= ST_GRANT;
            cc_mux_r  <= CC_SERVICE;
            timeout_r <= 1'b0;
          end
        end

        ST_RELEASE: begin
          // Always drop back to IDLE so every grant sees a fresh arbitration.
          state_r   <= ST_IDLE;
          ptr_r     <= next_ptr(grant_id_r);
          grant_r   <= {N_REQ{1'b0}};
          cc_mux_r  <= CC_IDLE;
          busy_r    <= 1'b0;
          timeout_r <= 1'b0;
        end

        default: begin
          state_r   <= ST_IDLE;
          grant_r   <= {N_REQ{1'b0}};
          cc_mux_r  <= CC_IDLE;
          busy_r    <= 1'b0;
          timeout_r <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_r;
  assign grant_id = grant_id_r;
  assign cc_mux   = cc_mux_r;
  assign busy     = busy_r;
  assign timeout  = timeout_r;

endmodule

// File: tb/tb_intr_req_arbiter.sv
module tb_intr_req_arbiter;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 8;
  localparam int ID_W    = $clog2(N_REQ);

  logic             clock;
  logic             reset_n;
  logic [N_REQ-1:0] req;
  logic             ack;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic [1:0]       cc_mux;
  logic             busy;
  logic             timeout;

  int total;
  int bad;

  // Reference model: which phase the channel is in, who owns it, how long.
  int m_phase;   // 0 = free, 1 = owned, 2 = being handed back
  int m_ptr;
  int m_id;
  int m_age;     // cycles the current owner has held the channel
  bit m_expired;

  intr_req_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .ack     (ack),
    .grant   (grant),
    .grant_id(grant_id),
    .cc_mux  (cc_mux),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_ptr = 0; m_id = 0; m_age = 0; m_expired = 1'b0;
  endtask

  task automatic m_step(input logic [N_REQ-1:0] r, input logic a);
    int id;
    case (m_phase)
      0: begin
        for (int k = N_REQ - 1; k >= 0; k--) begin
          id = (m_ptr + k) % N_REQ;
          if (r[id]) begin
            m_id = id;
            m_phase = 1;
          end
        end
        m_age = 1;
        m_expired = 1'b0;
      end
      1: begin
        if (a || !r[m_id]) begin
          m_phase = 2; m_expired = 1'b0;
        end else if (m_age == TIMEOUT) begin
          m_phase = 2; m_expired = 1'b1;
        end else begin
          m_age++;
        end
      end
      default: begin
        m_ptr = (m_id + 1) % N_REQ;
        m_phase = 0;
        m_expired = 1'b0;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [N_REQ-1:0] eg;
    eg = '0;
    if (m_phase == 1) eg[m_id] = 1'b1;
    chk_val("grant", 32'(grant), 32'(eg));
    chk_val("grant_id", 32'(grant_id), 32'(m_id));
    chk_val("cc_mux", 32'(cc_mux), 32'(m_phase + 1));
    chk_val("busy", 32'(busy), 32'(m_phase != 0));
    chk_val("timeout", 32'(timeout), 32'(m_phase == 2 && m_expired));
    chk_val("inv_onehot", 32'($onehot0(grant)), 32'd1);
    chk_val("inv_cc_nz", 32'(cc_mux != 2'b00), 32'd1);
  endtask

  // One clock: drive at negedge, model and DUT both take the edge, check at next negedge.
  task automatic run_cycle(input logic [N_REQ-1:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clock);
    m_step(r, a);
    @(negedge clock);
    compare_all();
  endtask

  logic [N_REQ-1:0] order_exp [5];
  logic [N_REQ-1:0] rq;
  int n;

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; req = '0; ack = 1'b0;
    m_reset();
    order_exp[0] = 4'b0001; order_exp[1] = 4'b0010; order_exp[2] = 4'b0100;
    order_exp[3] = 4'b1000; order_exp[4] = 4'b0001;
    repeat (2) @(negedge clock);
    compare_all();
    reset_n = 1'b1;

    // Quiet channel after reset.
    for (int i = 0; i < 10; i++) run_cycle(4'b0000, 1'b0);

    // Full contention: strict rotation with a 3-cycle period.
    for (int g = 0; g < 5; g++) begin
      run_cycle(4'b1111, 1'b0);
      chk_val("rotation", 32'(grant), 32'(order_exp[g]));
      run_cycle(4'b1111, 1'b1);
      run_cycle(4'b1111, 1'b0);
    end

    // Single requester 2, acked on the fourth edge.
    for (int i = 0; i < 3; i++) begin
      run_cycle(4'b0100, 1'b0);
      chk_val("req2_grant", 32'(grant), 32'h4);
      chk_val("req2_id", 32'(grant_id), 32'd2);
    end
    run_cycle(4'b0100, 1'b1);
    chk_val("req2_release", 32'(cc_mux), 32'h3);
    run_cycle(4'b0000, 1'b0);
    chk_val("req2_idle", 32'(cc_mux), 32'h1);
    run_cycle(4'b1111, 1'b0);
    chk_val("ptr_after_2", 32'(grant), 32'h8);
    run_cycle(4'b1111, 1'b1);
    run_cycle(4'b0000, 1'b0);

    // Unacknowledged grant runs to expiry.
    run_cycle(4'b0001, 1'b0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      run_cycle(4'b0001, 1'b0);
      if (grant != 4'b0001) break;
      n++;
    end
    chk_val("timeout_len", 32'(n), 32'(TIMEOUT));
    chk_val("timeout_pulse", 32'(timeout), 32'd1);
    chk_val("timeout_cc", 32'(cc_mux), 32'h3);
    run_cycle(4'b0001, 1'b0);
    chk_val("timeout_clear", 32'(timeout), 32'd0);
    run_cycle(4'b0001, 1'b0);
    chk_val("regrant", 32'(grant), 32'h1);

    // ack on the very edge that would have expired the grant.
    for (int i = 0; i < TIMEOUT - 1; i++) run_cycle(4'b0001, 1'b0);
    run_cycle(4'b0001, 1'b1);
    chk_val("ack_wins_to", 32'(timeout), 32'd0);
    chk_val("ack_wins_cc", 32'(cc_mux), 32'h3);
    run_cycle(4'b0000, 1'b0);

    // Asynchronous reset in the middle of a grant.
    run_cycle(4'b0100, 1'b0);
    run_cycle(4'b0100, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk_val("arst_grant", 32'(grant), 32'h0);
    chk_val("arst_cc", 32'(cc_mux), 32'h1);
    m_reset();
    @(negedge clock);
    compare_all();
    reset_n = 1'b1;
    run_cycle(4'b0010, 1'b0);
    chk_val("post_rst_grant", 32'(grant), 32'h2);
    run_cycle(4'b0010, 1'b1);
    run_cycle(4'b0000, 1'b0);

    // Randomised traffic against the model.
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) rq = N_REQ'($urandom_range(0, 15));
      run_cycle(rq, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intr_req_arbiter.md
# intr_req_arbiter

Round-robin arbiter that shares one interrupt/acknowledge handshake channel among `N_REQ` level-sensitive requesters. It sits in front of the single interrupt handler FSM. It grants one requester at a time and drives the handler's channel-control code. It sequences grant, service and release phases, and forcibly reclaims the channel when a grant is not acknowledged within `TIMEOUT` cycles.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `TIMEOUT`, default 8: maximum cycles a grant may stay open without `ack`; legal range 2..255.
- `clock`, input, 1: single clock; all state changes on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `req`, input, `N_REQ`: level request per requester; bit i = requester i.
- `ack`, input, 1: handler reports the current grant's service complete. Only meaningful in GRANT.
- `grant`, output, `N_REQ`: one-hot grant, or all zero; registered.
- `grant_id`, output, clog2(`N_REQ`): index of the current or most recent grantee; registered.
- `cc_mux`, output, 2: channel control code. 01 = idle/enable, 10 = interrupt in service, 11 = acknowledge/release. Never 00.
- `busy`, output, 1: high in GRANT and RELEASE.
- `timeout`, output, 1: one-cycle pulse, high during the RELEASE cycle caused by a timeout.

## Operation
- Reset: the asynchronous assert takes effect immediately, mid-operation included. It sets:
  - state = IDLE, `grant` = 0, `grant_id` = 0, `cc_mux` = 01, `busy` = 0, `timeout` = 0;
  - round-robin pointer `ptr` = 0, counter `cnt` = 0.
- Every output is a registered function of state; nothing is combinational from inputs.
- IDLE (`cc_mux` = 01, `grant` = 0):
  - With any `req` bit set, choose the first set index scanning `ptr`, `ptr`+1, … modulo `N_REQ`.
  - Load `grant_id` and the one-hot `grant`, clear `cnt`, go to GRANT.
  - With no request, stay in IDLE.
- GRANT (`cc_mux` = 10, `busy` = 1):
  - `cnt` increments each cycle, saturating at `TIMEOUT`.
  - Priority order, evaluated each edge:
    - `ack` = 1: go to RELEASE, `timeout` = 0.
    - `req[grant_id]` = 0 (requester withdrew): go to RELEASE, `timeout` = 0.
    - `cnt` = `TIMEOUT`-1: go to RELEASE, `timeout` = 1.
    - Otherwise stay in GRANT.
- RELEASE (`cc_mux` = 11, `grant` = 0, `busy` = 1):
  - Lasts exactly one cycle.
  - `ptr` := (`grant_id`+1) mod `N_REQ`; `timeout` then clears.
  - Always returns to IDLE; it never chains directly into a new grant.
- `grant_id` holds its value through RELEASE and IDLE until the next grant.
- Width rules:
  - `cnt` is clog2(`TIMEOUT`+1) bits.
  - The `ptr` increment wraps from `N_REQ`-1 to 0. For non-power-of-2 `N_REQ`, wrap explicitly; never rely on natural overflow.
- Boundary conditions:
  - `ack` together with timeout expiry: `ack` wins, no `timeout` pulse.
  - `ack` together with request withdrawal: normal release.
  - `ack` outside GRANT: ignored.
  - All requesters active: strict rotation 0,1,2,3,0…
  - A request that drops while in IDLE is never granted.
  - Starvation bound: a continuously asserted request is granted within `N_REQ`-1 intervening grants.

## Timing
- Request-to-grant latency: `req` sampled high at edge k in IDLE gives `grant` high after edge k, one cycle.
- Release latency: `ack` sampled at edge k in GRANT gives `grant` low and `cc_mux` = 11 after edge k.
- Back-to-back grants: minimum period 3 cycles (GRANT ≥ 1, RELEASE 1, IDLE 1).
- Maximum grant duration: `TIMEOUT` cycles, then 1 RELEASE cycle.
- Invariants that must hold in every cycle:
  - `grant` is one-hot or zero.
  - `grant` ≠ 0 exactly when `cc_mux` = 10.
  - `timeout` implies `cc_mux` = 11.
  - `cc_mux` ≠ 00.

## Test plan
- Reset, then `req` = 0000 for 10 cycles: outputs hold `grant` = 0000, `cc_mux` = 01, `busy` = 0, `timeout` = 0.
- `req` = 0100 at edge 1, `ack` at edge 4:
  - `grant` = 0100 and `grant_id` = 2 in cycles 1–3;
  - `cc_mux` = 11 in cycle 4, then 01 in cycle 5;
  - next `ptr` = 3.
- `req` = 1111 held, `ack` one cycle after each grant: grant order 0001, 0010, 0100, 1000, 0001, with a 3-cycle period.
- `req` = 0001 held, no `ack`, `TIMEOUT` = 8:
  - `grant` = 0001 for exactly 8 cycles;
  - then `timeout` = 1 with `cc_mux` = 11 for one cycle;
  - then the requester is re-granted after IDLE.
- `ack` asserted on the same edge where `cnt` = `TIMEOUT`-1: normal release, `timeout` stays 0.
- `reset_n` dropped mid-GRANT, then `req` = 0010 after deassert:
  - `grant` = 0 and `cc_mux` = 01 immediately, without waiting for a clock edge;
  - after deassert, the first grant is 0010 and rotation restarts from `ptr` = 0.
